// File: rtl/adc_spi_pkg.sv
// Shared definitions for the 3-wire ADC configuration link (master and responder).
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned ADDR_BITS  = 7;
    localparam int unsigned DATA_BITS  = 16;
    localparam logic        RW_READ    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer with a third stage for registered rise/fall detection.
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;
    logic rise_q, fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            s3_q   <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_responder.sv
// 3-wire serial register target: oversamples the master's link, decodes
// 24-bit R/W frames and serves them from an internal register file.
module spi_reg_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter logic [15:0] ID_VALUE = 16'h5401
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sclk,
    input  logic                   sdenb,
    input  logic                   sdio,
    output logic                   sdo,
    output logic                   sdo_oe,
    output logic                   wr_valid,
    output logic [6:0]             wr_addr,
    output logic [15:0]            wr_data,
    output logic [16*NUM_REGS-1:0] regs_flat,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    logic sclk_rise, sclk_fall;

    sync_edge #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk_i  (clk),
        .rst_i  (reset),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    logic sdenb_s1_q, sdenb_s2_q, sdenb_prev_q;
    logic sdio_s1_q, sdio_s2_q;
    logic [1:0] settle_q;
    logic armed_q;

    // The preset synchronizer stages would fake an sdenb fall if reset
    // releases mid-frame, so frame starts are only honoured once sdenb
    // has been seen high after the pipeline has flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdenb_s1_q   <= 1'b1;
            sdenb_s2_q   <= 1'b1;
            sdenb_prev_q <= 1'b1;
            sdio_s1_q    <= 1'b0;
            sdio_s2_q    <= 1'b0;
            settle_q     <= '0;
            armed_q      <= 1'b0;
        end else begin
            sdenb_s1_q   <= sdenb;
            sdenb_s2_q   <= sdenb_s1_q;
            sdenb_prev_q <= sdenb_s2_q;
            sdio_s1_q    <= sdio;
            sdio_s2_q    <= sdio_s1_q;
            if (settle_q != 2'd3)
                settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd3 && sdenb_s2_q)
                armed_q <= 1'b1;
        end
    end

    logic sdenb_fall, sdenb_rise;
    assign sdenb_fall = armed_q & sdenb_prev_q & ~sdenb_s2_q;
    assign sdenb_rise = sdenb_s2_q & ~sdenb_prev_q;

    spi_state_e                 state_q;
    logic [4:0]                 bit_cnt_q;
    logic [FRAME_BITS-2:0]      sh_q;
    logic [FRAME_BITS-1:0]      sh_next;
    logic                       rw_q;
    logic [ADDR_BITS-1:0]       addr_q;
    logic [DATA_BITS-1:0]       shadow_q;
    logic [DATA_BITS-1:0]       rd_data;
    logic [DATA_BITS-1:0]       regs_q [NUM_REGS];
    logic                       sdo_q, sdo_oe_q, wr_valid_q, frame_err_q;
    logic [ADDR_BITS-1:0]       wr_addr_q;
    logic [DATA_BITS-1:0]       wr_data_q;
    logic [15:0]                frame_cnt_q;

    assign sh_next = {sh_q, sdio_s2_q};

    // reg0 holds ID_VALUE and is never written, so it serves reads directly.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (sh_next[ADDR_BITS-1:0] == ADDR_BITS'(i))
                rd_data = regs_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            shadow_q    <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == 0) ? ID_VALUE : '0;
        end else begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q <= '0;
                    sdo_q     <= 1'b0;
                    sdo_oe_q  <= 1'b0;
                    if (sdenb_fall)
                        state_q <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (sdenb_rise) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                    end else if (sclk_rise) begin
                        sh_q      <= sh_next[FRAME_BITS-2:0];
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(ADDR_BITS)) begin
                            rw_q     <= sh_next[ADDR_BITS];
                            addr_q   <= sh_next[ADDR_BITS-1:0];
                            shadow_q <= rd_data;
                            sdo_oe_q <= (sh_next[ADDR_BITS] == RW_READ);
                            state_q  <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sdenb_rise) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        sdo_q       <= 1'b0;
                        sdo_oe_q    <= 1'b0;
                    end else begin
                        if (sclk_fall && rw_q == RW_READ) begin
                            sdo_q    <= shadow_q[DATA_BITS-1];
                            shadow_q <= {shadow_q[DATA_BITS-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            sh_q      <= sh_next[FRAME_BITS-2:0];
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                                if (rw_q != RW_READ) begin
                                    wr_valid_q <= 1'b1;
                                    wr_addr_q  <= addr_q;
                                    wr_data_q  <= sh_next[DATA_BITS-1:0];
                                    for (int unsigned i = 1; i < NUM_REGS; i++)
                                        if (addr_q == ADDR_BITS'(i))
                                            regs_q[i] <= sh_next[DATA_BITS-1:0];
                                end
                                sdo_q    <= 1'b0;
                                sdo_oe_q <= 1'b0;
                                state_q  <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (sdenb_rise) begin
                        state_q     <= ST_IDLE;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            regs_flat[DATA_BITS*i +: DATA_BITS] = regs_q[i];
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized bench for spi_reg_responder: drives /8 master frames and checks
// against an array-based register model.
module tb_spi_reg_responder;

    localparam int unsigned NREGS = 32;
    localparam logic [15:0] ID    = 16'h5401;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b1;
    logic sdenb = 1'b1;
    logic sdio = 1'b0;
    logic sdo, sdo_oe, wr_valid, frame_err;
    logic [6:0] wr_addr;
    logic [15:0] wr_data, frame_cnt;
    logic [16*NREGS-1:0] regs_flat;

    spi_reg_responder #(.NUM_REGS(NREGS), .ID_VALUE(ID)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .sdenb     (sdenb),
        .sdio      (sdio),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .regs_flat (regs_flat),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [128];
    int exp_fc = 0, exp_wr = 0, exp_err = 0;
    logic [6:0] exp_wa = '0;
    logic [15:0] exp_wd = '0;

    int wr_seen = 0, err_seen = 0;
    logic [6:0] wa_seen = '0;
    logic [15:0] wd_seen = '0;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_seen++;
            wa_seen = wr_addr;
            wd_seen = wr_data;
        end
        if (frame_err) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdl_read(input int a);
        if (a == 0) return ID;
        if (a < int'(NREGS)) return mdl[a];
        return 16'h0000;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 128; i++) mdl[i] = '0;
        exp_fc = 0;
        exp_wa = '0;
        exp_wd = '0;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string ctx);
        chk({ctx, "_frame_cnt"}, {16'h0, frame_cnt}, {16'h0, exp_fc[15:0]});
        chk({ctx, "_wr_pulses"}, wr_seen, exp_wr);
        chk({ctx, "_wr_addr"}, {25'h0, wr_addr}, {25'h0, exp_wa});
        chk({ctx, "_wr_data"}, {16'h0, wr_data}, {16'h0, exp_wd});
        chk({ctx, "_err_pulses"}, err_seen, exp_err);
        chk({ctx, "_sdo_idle"}, {31'h0, sdo}, 32'h0);
        chk({ctx, "_sdo_oe_idle"}, {31'h0, sdo_oe}, 32'h0);
        for (int i = 0; i < int'(NREGS); i++)
            chk($sformatf("%s_reg%0d", ctx, i), {16'h0, regs_flat[16*i +: 16]},
                {16'h0, mdl_read(i)});
    endtask

    // Master at clk/8: data changes on sclk fall, target samples on rise.
    task automatic drive_frame(input logic rw, input logic [6:0] a, input logic [15:0] d,
                               input int nbits, input int rst_at, output logic [15:0] rd);
        logic [23:0] fr;
        bit live;
        fr = {rw, a, d};
        rd = '0;
        live = 1'b1;
        sdenb = 1'b0;
        ticks(4);
        for (int k = 0; k < nbits; k++) begin
            sclk = 1'b0;
            sdio = (k < 24) ? fr[23-k] : 1'b0;
            ticks(4);
            sclk = 1'b1;
            ticks(2);
            if (live && k >= 8 && k < 24) begin
                if (rw) begin
                    rd = {rd[14:0], sdo};
                    chk("sdo_oe_read", {31'h0, sdo_oe}, 32'h1);
                end else begin
                    chk("sdo_oe_write", {31'h0, sdo_oe}, 32'h0);
                end
            end
            ticks(2);
            if (k == rst_at) begin
                reset = 1'b1;
                live = 1'b0;
                ticks(2);
                mdl_reset();
                chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
                chk("rst_sdo", {31'h0, sdo}, 32'h0);
                chk("rst_sdo_oe", {31'h0, sdo_oe}, 32'h0);
                chk("rst_wr_addr", {25'h0, wr_addr}, 32'h0);
                chk("rst_wr_data", {16'h0, wr_data}, 32'h0);
                chk("rst_reg0", {16'h0, regs_flat[15:0]}, {16'h0, ID});
                ticks(1);
                reset = 1'b0;
            end
        end
        ticks(4);
        sdenb = 1'b1;
        ticks(10);
    endtask

    task automatic run_frame(input logic rw, input logic [6:0] a, input logic [15:0] d,
                             input int nbits);
        logic [15:0] rd;
        logic [15:0] exp_rd;
        exp_rd = mdl_read(int'(a));
        drive_frame(rw, a, d, nbits, -1, rd);
        if (nbits < 24) begin
            exp_err++;
        end else begin
            exp_fc++;
            if (rw) begin
                chk($sformatf("read_data_a%0d", a), {16'h0, rd}, {16'h0, exp_rd});
            end else begin
                exp_wr++;
                exp_wa = a;
                exp_wd = d;
                if (a != 0 && int'(a) < int'(NREGS)) mdl[a] = d;
            end
        end
        check_state(nbits < 24 ? "trunc" : (rw ? "rd" : "wr"));
    endtask

    initial begin
        logic [15:0] dummy;
        int r;
        logic [6:0] a;
        int nb;

        mdl_reset();
        ticks(3);
        chk("reset_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        chk("reset_wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
        reset = 1'b0;
        ticks(8);
        check_state("reset");

        run_frame(1'b0, 7'h05, 16'hBEEF, 24);
        run_frame(1'b1, 7'h05, 16'h0000, 24);
        run_frame(1'b1, 7'h00, 16'h1111, 24);
        run_frame(1'b1, 7'h7F, 16'h2222, 24);
        run_frame(1'b0, 7'h00, 16'hFFFF, 24);
        run_frame(1'b0, 7'h03, 16'hA5A5, 12);
        run_frame(1'b1, 7'h05, 16'h0000, 24);
        run_frame(1'b0, 7'h02, 16'h1234, 30);
        run_frame(1'b1, 7'h02, 16'h0000, 24);

        // Reset asserted in the DATA phase of a write; the frame keeps clocking.
        drive_frame(1'b0, 7'h04, 16'h5555, 24, 13, dummy);
        check_state("after_rst");
        run_frame(1'b0, 7'h04, 16'h00AA, 24);
        run_frame(1'b1, 7'h04, 16'h0000, 24);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 7'h7F;
            else if (r == 1) a = 7'($urandom_range(NREGS, 126));
            else             a = 7'($urandom_range(0, NREGS - 1));
            r = $urandom_range(0, 9);
            if (r == 0)      nb = $urandom_range(0, 23);
            else if (r == 1) nb = $urandom_range(25, 30);
            else             nb = 24;
            run_frame(1'($urandom_range(0, 1)), a, 16'($urandom), nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/spi_reg_responder.md
# spi_reg_responder

Serial-register responder for the 3-wire ADC configuration interface: it emulates the ADS5401-style target that the configuration FPGA's serial master drives. It oversamples `sclk`/`sdenb`/`sdio` in the fast `clk` domain, decodes 24-bit frames (R/W, 7-bit address, 16-bit data), and serves writes and reads from an internal register file. It is used as a bench/loopback target for the master and as a configuration endpoint on boards without a real ADC.

## Interface
- `NUM_REGS`, 32: implemented registers, addresses 0..NUM_REGS-1; maximum 128.
- `ID_VALUE`, 16'h5401: read-only contents of address 0x00.
- `clk`  in  1  system clock; the serial master derives `sclk` from this same clock divided by 8.
- `reset`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  serial clock from master; idles high between frames.
- `sdenb`  in  1  active-low frame enable.
- `sdio`  in  1  serial data from master, MSB first.
- `sdo`  out  1  serial read data to master (`sdi` at master).
- `sdo_oe`  out  1  high while read data is driven.
- `wr_valid`  out  1  one-`clk` pulse per committed write.
- `wr_addr`  out  7  address of last committed write.
- `wr_data`  out  16  data of last committed write.
- `regs_flat`  out  16*NUM_REGS  register file, reg n at [16n+15:16n].
- `frame_err`  out  1  one-`clk` pulse on a truncated frame.
- `frame_cnt`  out  16  count of complete frames, wraps at 0xFFFF->0.

## Operation
- Inputs `sclk`, `sdenb`, `sdio` pass through 2-FF synchronizers; a third `sclk` stage detects rise and fall edges. Data and clock see equal delay.
- Frame bit order: bit23 = R/W (1 = read), bits 22:16 = address, bits 15:0 = data.
- FSM states:
  - IDLE: `bit_cnt`=0. Go to ADDR when synced `sdenb` falls.
  - ADDR: shift `sdio` on each sclk rise. After the 8th rise, latch `rw` and `addr`, latch the read shadow = reg[addr], and go to DATA.
  - DATA: shift on each rise.
    - For a read, on each sclk fall drive `sdo` = shadow MSB, then shift the shadow left. `sdo_oe`=1.
    - On the 24th rise, a write commits and the FSM goes to DONE.
  - DONE: ignore further sclk edges. Go to IDLE when `sdenb` rises; `frame_cnt`+1.
- `sdenb` rise in ADDR or DATA: return to IDLE, pulse `frame_err`, no commit, `frame_cnt` unchanged. An `sdenb` rise in IDLE is ignored.
- Write commit: if addr ≠ 0 and addr < NUM_REGS, reg[addr] <= data. Pulse `wr_valid` with `wr_addr`/`wr_data` in every commit case, including ignored addresses.
- Read data sources:
  - addr 0: `ID_VALUE`.
  - addr ≥ NUM_REGS: 16'h0000.
- Outside a read DATA phase: `sdo`=0, `sdo_oe`=0.

## Timing
- Reset values: all registers 0 except reg0 = `ID_VALUE`. `sdo`=0, `sdo_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `frame_err`=0, `frame_cnt`=0. FSM in IDLE. Synchronizers preset to `sclk`=1, `sdenb`=1.
- `sclk` high and low times must each be ≥ 4 `clk`; the /8 master satisfies this with exactly 4.
- Edge detect occurs 3 `clk` after the pin transition.
- `sdo` updates 1 `clk` after fall detect, i.e. 4 `clk` after the `sclk` fall. This is stable before the master samples at the next `sclk` fall 8 `clk` later.
- Write commit: `wr_valid` and the `regs_flat` update both occur 1 `clk` after the 24th rise detect.
- Read-after-write in back-to-back frames returns the new value.
- Reset asserted mid-frame: the FSM aborts immediately with no commit and no `frame_err`. Frames already in flight when reset releases are ignored until the next `sdenb` fall.

## Structure
- Shared package `adc_spi_pkg`:
  - `FRAME_BITS`=24, `ADDR_BITS`=7, `DATA_BITS`=16, `RW_READ`=1'b1.
  - FSM state encoding.
  - The same package serves the master.
- One sub-module: `sync_edge` (2-FF synchronizer plus rise/fall detect), instanced for `sclk`. Plain 2-FF synchronizers for `sdenb` and `sdio`.

## Test plan
- Write 0x05 = 0xBEEF: reg5 = 0xBEEF, one `wr_valid` pulse with `wr_addr`=5 and `wr_data`=0xBEEF, `frame_cnt`=1.
- Read 0x05 after that write: `sdo` shifts out 0xBEEF MSB first across bits 8..23, `sdo_oe`=1 only during DATA, master `data_out`=0x0000BEEF.
- Read 0x00 and 0x7F with NUM_REGS=32: returns 0x5401 and 0x0000. Write 0xFFFF to 0x00: reg0 stays 0x5401, `wr_valid` still pulses.
- Truncated frame: `sdenb` rises after 12 bits of a write to 0x03 → `frame_err` pulse, reg3 unchanged, `frame_cnt` unchanged. The next full frame decodes correctly.
- 30 sclk cycles under one `sdenb` for a write of 0x1234 to 0x02: commit happens at bit 24, extra clocks are ignored, reg2 = 0x1234.
- Async reset asserted during DATA of a write to 0x04: no commit, all outputs return to reset values, a subsequent write to 0x04 of 0x00AA succeeds.
